// File: rtl/hamming_encoder_pipe.sv
// hamming_encoder_pipe: two-stage valid/ready Hamming(71,64) encoder with per-word single-bit error injection.
// Codeword index n carries 1-indexed position n+1; parity sits at the power-of-two positions.
module hamming_encoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [63:0]      data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             inj_en,
  input  logic [6:0]       inj_pos,
  output logic [70:0]      codeword_out,
  output logic [6:0]       parity_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count
);
  logic             r_run;
  logic             r_s1_valid;
  logic [63:0]      r_s1_data;
  logic             r_s1_inj_en;
  logic [6:0]       r_s1_inj_pos;
  logic [70:0]      r_cw;
  logic [6:0]       r_par;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;
  logic             w_s2_take;
  logic             w_s1_take;
  logic             w_accept;
  logic [70:0]      w_data_cw;
  logic [70:0]      w_cw;
  logic [70:0]      w_flip;
  logic [6:0]       w_par;
  logic [70:0]      w_cov [7];

  assign w_s2_take = !r_out_valid | out_ready;
  assign w_s1_take = !r_s1_valid | w_s2_take;
  assign in_ready  = r_run & enable & w_s1_take;
  assign w_accept  = in_valid & in_ready;

  // Position n+1 is a parity slot when it is a power of two; data bits fill the rest in order.
  for (genvar n = 0; n < 71; n++) begin : g_pos
    if (((n + 1) & n) == 0) begin : g_par
      assign w_data_cw[n] = 1'b0;
      assign w_cw[n]      = w_par[$clog2(n + 1)];
    end else begin : g_dat
      assign w_data_cw[n] = r_s1_data[n - $clog2(n + 2)];
      assign w_cw[n]      = w_data_cw[n];
    end
  end

  for (genvar k = 0; k < 7; k++) begin : g_pk
    for (genvar n = 0; n < 71; n++) begin : g_cv
      assign w_cov[k][n] = ((((n + 1) >> k) % 2) == 1) ? w_data_cw[n] : 1'b0;
    end
    assign w_par[k] = ^w_cov[k];
  end

  assign w_flip = (r_s1_inj_en && r_s1_inj_pos != 7'd0 && r_s1_inj_pos <= 7'd71)
                ? (71'd1 << (r_s1_inj_pos - 7'd1)) : '0;

  // r_run keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_inj_en  <= 1'b0;
      r_s1_inj_pos <= '0;
      r_out_valid  <= 1'b0;
      r_cw         <= '0;
      r_par        <= '0;
      r_count      <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_s1_take) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_data    <= data_in;
          r_s1_inj_en  <= inj_en;
          r_s1_inj_pos <= inj_pos;
        end
      end
      if (w_s2_take) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_cw  <= w_cw ^ w_flip;
          r_par <= w_par;
        end
      end
      if (r_out_valid && out_ready) r_count <= r_count + CNT_W'(1);
    end
  end

  assign codeword_out = r_cw;
  assign parity_out   = r_par;
  assign out_valid    = r_out_valid;
  assign word_count   = r_count;
endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// tb_hamming_encoder_pipe: randomized and directed bench with a positional Hamming model and a scoreboard queue.
module tb_hamming_encoder_pipe;
  logic        clk, rst_n, enable, in_valid, in_ready, inj_en, out_valid, out_ready;
  logic [63:0] data_in;
  logic [6:0]  inj_pos, parity_out;
  logic [70:0] codeword_out;
  logic [15:0] word_count;

  hamming_encoder_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .inj_en(inj_en), .inj_pos(inj_pos), .codeword_out(codeword_out),
    .parity_out(parity_out), .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count)
  );

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [6:0]  p;
  } item_t;

  item_t       q[$];
  int          n_chk, n_fail, hs_total;
  bit          acc, seen_hs, stall_prev, do_cnt;
  logic [70:0] hs_cw, prev_cw;
  logic [6:0]  hs_par, prev_par;
  logic [15:0] exp_cnt;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data bits go to non-power-of-two positions; parity = XOR of positions holding a 1.
  function automatic logic [77:0] enc(input logic [63:0] d);
    logic [70:0] cw;
    int j, s;
    cw = '0; j = 0; s = 0;
    for (int pos = 1; pos <= 71; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        if (d[j]) s ^= pos;
        j++;
      end
    for (int k = 0; k < 7; k++) cw[(1 << k) - 1] = s[k];
    return {s[6:0], cw};
  endfunction

  function automatic logic [70:0] dec(input logic [70:0] cw_in);
    logic [70:0] cw;
    logic [63:0] d;
    int j, s;
    cw = cw_in; d = '0; j = 0; s = 0;
    for (int pos = 1; pos <= 71; pos++) if (cw[pos-1]) s ^= pos;
    if (s >= 1 && s <= 71) cw[s-1] = ~cw[s-1];
    for (int pos = 1; pos <= 71; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[j] = cw[pos-1];
        j++;
      end
    return {s[6:0], d};
  endfunction

  // Called at a falling edge with inputs set; samples just before the next rising edge.
  task automatic cyc();
    item_t       e;
    logic [77:0] m;
    logic [70:0] ecw, dr;
    int          p;
    #1;
    if (stall_prev) begin
      chk("hold_cw", codeword_out, prev_cw);
      chk("hold_par", parity_out, prev_par);
    end
    if (!enable) chk("en_ready", in_ready, 0);
    if (do_cnt) chk("count", word_count, exp_cnt);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious", out_valid, 0);
      else begin
        e = q.pop_front();
        m = enc(e.d);
        ecw = m[70:0];
        p = int'(e.p);
        if (e.e && p >= 1 && p <= 71) ecw[p-1] = ~ecw[p-1];
        dr = dec(codeword_out);
        chk("cw", codeword_out, ecw);
        chk("par", parity_out, m[77:71]);
        chk("dec_data", dr[63:0], e.d);
        chk("dec_syn", dr[70:64], (e.e && p >= 1 && p <= 71) ? p : 0);
      end
      exp_cnt++;
      hs_total++;
      seen_hs = 1;
      hs_cw = codeword_out;
      hs_par = parity_out;
    end
    if (acc) q.push_back('{d: data_in, e: inj_en, p: inj_pos});
    stall_prev = out_valid && !out_ready;
    prev_cw = codeword_out;
    prev_par = parity_out;
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    #2 rst_n = 0;
    #1;
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_cnt"}, word_count, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_cw"}, codeword_out, 0);
    chk({tag, "_par"}, parity_out, 0);
    q.delete();
    exp_cnt = 0; stall_prev = 0; acc = 0; in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1 chk({tag, "_rdy_rel"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_rdy_up"}, in_ready, 1);
  endtask

  task automatic send_one(input string tag, input logic [63:0] d, input logic ie, input logic [6:0] ip,
                          input logic [70:0] ecw, input logic [6:0] ep);
    int lat;
    data_in = d; inj_en = ie; inj_pos = ip; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk({tag, "_acc"}, acc, 1);
    seen_hs = 0; lat = 0;
    while (!seen_hs && lat < 10) begin
      cyc();
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_cw"}, hs_cw, ecw);
    chk({tag, "_par"}, hs_par, ep);
  endtask

  task automatic drain(input string tag);
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) cyc();
    chk({tag, "_empty"}, q.size(), 0);
  endtask

  initial begin
    int start, guard, accepted;
    n_chk = 0; n_fail = 0; hs_total = 0; exp_cnt = 0;
    rst_n = 1; enable = 1; in_valid = 0; inj_en = 0; inj_pos = 0; data_in = 0; out_ready = 1;
    do_cnt = 1; stall_prev = 0; acc = 0; seen_hs = 0;
    apply_reset("por");

    send_one("zero", 64'h0, 0, 7'd0, 71'h0, 7'h00);
    chk("cnt1", word_count, 1);
    send_one("one", 64'h1, 0, 7'd0, 71'h7, 7'b0000011);
    send_one("one_inj5", 64'h1, 1, 7'd5, 71'h17, 7'b0000011);
    send_one("msb", 64'h8000_0000_0000_0000, 0, 7'd0, 71'h40_8000_0000_0000_000B, 7'b1000111);
    send_one("msb_inj0", 64'h8000_0000_0000_0000, 1, 7'd0, 71'h40_8000_0000_0000_000B, 7'b1000111);
    send_one("msb_inj72", 64'h8000_0000_0000_0000, 1, 7'd72, 71'h40_8000_0000_0000_000B, 7'b1000111);
    send_one("msb_inj71", 64'h8000_0000_0000_0000, 1, 7'd71, 71'h00_8000_0000_0000_000B, 7'b1000111);

    apply_reset("bp");
    out_ready = 0; in_valid = 1; inj_en = 0;
    data_in = {$urandom, $urandom}; cyc(); chk("bp_a", acc, 1);
    data_in = {$urandom, $urandom}; cyc(); chk("bp_b", acc, 1);
    data_in = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_c_held", acc, 0);
    end
    out_ready = 1;
    cyc(); chk("bp_c", acc, 1);
    in_valid = 0;
    start = hs_total;
    cyc(); cyc();
    chk("bp_rate", hs_total - start, 2);
    chk("bp_cnt3", word_count, 3);

    out_ready = 0; in_valid = 1;
    data_in = {$urandom, $urandom}; cyc(); chk("en_x", acc, 1);
    data_in = {$urandom, $urandom}; cyc(); chk("en_y", acc, 1);
    enable = 0; out_ready = 1; data_in = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) cyc();
    chk("en_drained", q.size(), 0);
    in_valid = 0; enable = 1;
    cyc();

    out_ready = 0; in_valid = 1;
    data_in = {$urandom, $urandom}; cyc();
    data_in = {$urandom, $urandom}; cyc();
    in_valid = 0;
    chk("rst_inflight", q.size(), 2);
    apply_reset("rst_mid");
    out_ready = 1;
    for (int i = 0; i < 6; i++) cyc();

    accepted = 0; guard = 0; in_valid = 0; acc = 0;
    while (accepted < 1000 && guard < 10000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 4) != 0);
        data_in = {$urandom, $urandom};
        inj_en = 1'($urandom_range(0, 1));
        inj_pos = 7'($urandom_range(0, 80));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cyc();
      if (acc) accepted++;
      guard++;
    end
    chk("rand_words", accepted, 1000);
    drain("rand");

    apply_reset("wrap");
    do_cnt = 0; in_valid = 1; out_ready = 1; inj_en = 0;
    start = hs_total; guard = 0;
    while (hs_total - start < 65535 && guard < 70000) begin
      data_in = {$urandom, $urandom};
      cyc();
      guard++;
    end
    chk("wrap_ffff", word_count, 16'hFFFF);
    cyc();
    chk("wrap_zero", word_count, 0);
    do_cnt = 1;
    drain("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
